mux2_rr_arbiter: RTL

//  Round-robin controller for a shared 2:1 mux: arbitrates two packet requesters (A, B) onto one output channel.

---
 rtl/mux2_rr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 packet mux controller with a registered valid/ready output stage.
// Define MUX_ARB_TIMEOUT_EN to force a grant release after MAX_BEATS beats.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    input  logic             A_last,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    input  logic             B_last,
    output logic             B_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             select,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle = 2'd0, StGrantA = 2'd1, StGrantB = 2'd2} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_last_winner;  // 0 = A, 1 = B
    logic             r_select;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;

    logic             w_out_free;
    logic             w_grant_b;
    logic             w_xfer;
    logic             w_x_last;
    logic [WIDTH-1:0] w_x_data;
    logic             w_timeout;
    logic             w_release;

    if (MAX_BEATS < 1 || MAX_BEATS > 256) begin : g_bad_max_beats
        $error("MAX_BEATS must lie in 1..256 to fit the 8-bit beat counter");
    end

    assign w_out_free = !r_out_valid || out_ready;
    assign w_grant_b  = (r_state == StGrantB);
    assign w_xfer     = w_grant_b ? (B_valid && B_ready) : (A_valid && A_ready);
    assign w_x_last   = w_grant_b ? B_last : A_last;
    assign w_x_data   = w_grant_b ? B_data : A_data;
    assign w_release  = w_xfer && (w_x_last || w_timeout);

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] r_beat_cnt;

    // Counts beats already taken under the current grant; zero on every grant entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= 8'd0;
        end else if (r_state == StIdle || w_release) begin
            r_beat_cnt <= 8'd0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_beat_cnt == 8'(MAX_BEATS - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register, plus select and round-robin history which follow the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_select      <= 1'b0;
            r_last_winner <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == StGrantA) begin
                r_select <= 1'b0;
            end else if (w_state_next == StGrantB) begin
                r_select <= 1'b1;
            end
            if (w_release) begin
                r_last_winner <= w_grant_b;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (A_valid && (!B_valid || r_last_winner)) begin
                    w_state_next = StGrantA;
                end else if (B_valid) begin
                    w_state_next = StGrantB;
                end
            end
            StGrantA: begin
                if (w_release) begin
                    w_state_next = B_valid ? StGrantB : StIdle;
                end
            end
            StGrantB: begin
                if (w_release) begin
                    w_state_next = A_valid ? StGrantA : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        A_ready = (r_state == StGrantA) && w_out_free;
        B_ready = (r_state == StGrantB) && w_out_free;
        busy    = (r_state != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_x_data;
            r_out_last  <= w_x_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign select    = r_select;

endmodule
